// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the shift sequencer: FSM states, shift modes, directions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Encoding 2'b11 is reserved and behaves as a logical shift.
  typedef enum logic [1:0] {
    MODE_LOG = 2'b00,
    MODE_ROT = 2'b01,
    MODE_ARI = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_step.sv
// Single-position shifter: one bit of logical, rotate or arithmetic shift.
// Latency: combinational.
// Backpressure: none.
// Ports: q (current value), dir (1=right), mode (shift kind) -> q_nxt (value after one step).
module shift_step
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] q_nxt
);

  logic fill_r;  // bit entering at the MSB on a right shift
  logic fill_l;  // bit entering at the LSB on a left shift

  always_comb begin
    fill_r = 1'b0;
    fill_l = 1'b0;
    q_nxt  = q;
    case (mode_e'(mode))
      MODE_ROT: begin
        fill_r = q[0];
        fill_l = q[WIDTH-1];
      end
      // Arithmetic left is a plain logical left, so only the right fill changes.
      MODE_ARI: fill_r = q[WIDTH-1];
      default: begin
        fill_r = 1'b0;
        fill_l = 1'b0;
      end
    endcase
    if (dir == DIR_RIGHT) q_nxt = {fill_r, q[WIDTH-1:1]};
    else                  q_nxt = {q[WIDTH-2:0], fill_l};
  end

endmodule

// File: rtl/shift_sequencer.sv
// Sequenced multi-bit shifter: one bit position per clock under an IDLE/SHIFT/DONE FSM.
// Latency: start at edge k -> q final after edge k+N, done high in the following cycle.
// Backpressure: while busy every command input (load/start/din/dir/mode/cnt) is ignored.
// Ports: clk, rst (sync, active-high); load/din parallel load; start/dir/mode/cnt command;
//        q register contents; busy = not IDLE; done = one-cycle completion pulse.
module shift_sequencer
  import shift_ctrl_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               CNT_W    = 4,
  parameter logic [WIDTH-1:0] INIT_VAL = WIDTH'(8'b01100110)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] cnt,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  // Remaining-count register must hold WIDTH itself (full logical shift-out).
  localparam int REM_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   step_q;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [REM_W-1:0]   eff_cnt;
  logic               dir_q, dir_d;
  logic [1:0]         mode_q, mode_d;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .q     (q_q),
    .dir   (dir_q),
    .mode  (mode_q),
    .q_nxt (step_q)
  );

  // Shifting past WIDTH is pointless for fill modes, and rotation is periodic in WIDTH.
  always_comb begin
    eff_cnt = '0;
    if (mode_e'(mode) == MODE_ROT)  eff_cnt = REM_W'(int'(cnt) % WIDTH);
    else if (int'(cnt) > WIDTH)     eff_cnt = REM_W'(WIDTH);
    else                            eff_cnt = REM_W'(cnt);
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    busy    = (state_q != IDLE);
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          q_d = din;
        end else if (start) begin
          dir_d   = dir;
          mode_d  = mode;
          rem_d   = eff_cnt;
          state_d = (eff_cnt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        q_d   = step_q;
        rem_d = rem_q - REM_W'(1);
        if (rem_q == REM_W'(1)) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= INIT_VAL;
      rem_q   <= '0;
      dir_q   <= DIR_LEFT;
      mode_q  <= MODE_LOG;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: cycle model built from closed-form shift arithmetic
// plus directed scenarios with hand-computed final values.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] din;
  logic       start;
  logic       dir;
  logic [1:0] mode;
  logic [3:0] cnt;
  logic [7:0] q;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_sequencer dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .din   (din),
    .start (start),
    .dir   (dir),
    .mode  (mode),
    .cnt   (cnt),
    .q     (q),
    .busy  (busy),
    .done  (done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Value after shifting v by s positions in one go.
  function automatic logic [7:0] shifted(input logic [7:0] v, input logic d,
                                         input logic [1:0] m, input int s);
    logic [7:0] r;
    case (m)
      2'b01:   r = d ? ((v >> s) | (v << (8 - s))) : ((v << s) | (v >> (8 - s)));
      2'b10:   r = d ? 8'($signed(v) >>> s) : (v << s);
      default: r = d ? (v >> s) : (v << s);
    endcase
    if (s == 0) r = v;
    return r;
  endfunction

  // ---------------- cycle model ----------------
  bit         m_valid = 0;
  bit         m_inop;
  int         m_t, m_n;
  logic [7:0] m_q, m_q0;
  logic       m_dir;
  logic [1:0] m_mode;
  bit         m_busy, m_done;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1;
      m_inop  = 0;
      m_q     = 8'h66;
      m_busy  = 0;
      m_done  = 0;
    end else if (m_valid) begin
      if (!m_inop) begin
        if (load) begin
          m_q = din;
        end else if (start) begin
          m_inop = 1;
          m_t    = 0;
          m_q0   = m_q;
          m_dir  = dir;
          m_mode = mode;
          m_n    = (mode == 2'b01) ? (int'(cnt) % 8) : ((int'(cnt) > 8) ? 8 : int'(cnt));
          m_busy = 1;
          m_done = (m_n == 0);
        end
      end else begin
        m_t++;
        if (m_t <= m_n) begin
          m_q    = shifted(m_q0, m_dir, m_mode, m_t);
          m_done = (m_t == m_n);
        end else begin
          m_inop = 0;
          m_busy = 0;
          m_done = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_q", {24'd0, q}, {24'd0, m_q});
      chk("model_busy", {31'd0, busy}, {31'd0, m_busy});
      chk("model_done", {31'd0, done}, {31'd0, m_done});
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic do_load(input logic [7:0] v);
    @(negedge clk);
    load = 1; din = v;
    @(negedge clk);
    load = 0;
    chk("load_q", {24'd0, q}, {24'd0, v});
  endtask

  // Issue one command and watch it to completion; optionally poke inputs mid-shift.
  task automatic do_op(input string nm, input logic d, input logic [1:0] m, input logic [3:0] c,
                       input logic [7:0] exp_q, input int exp_busy, input bit poke);
    int busy_cnt, done_cnt, n;
    @(negedge clk);
    start = 1; dir = d; mode = m; cnt = c;
    @(negedge clk);
    start = 0;
    busy_cnt = 0; done_cnt = 0; n = 0;
    while (busy && n < 40) begin
      busy_cnt++;
      if (done) done_cnt++;
      n++;
      @(negedge clk);
      if (poke && n == 1) begin
        load = 1; start = 1; din = 8'hFF; dir = ~d; mode = 2'b01; cnt = 4'd1;
      end else if (poke && n == 2) begin
        load = 0; start = 0; dir = d; mode = m; cnt = c;
      end
    end
    chk({nm, "_q"}, {24'd0, q}, {24'd0, exp_q});
    chk({nm, "_busy_cycles"}, busy_cnt, exp_busy);
    chk({nm, "_done_pulses"}, done_cnt, 1);
  endtask

  initial begin
    rst = 1; load = 0; start = 0; din = 8'h00; dir = 0; mode = 2'b00; cnt = 4'd0;
    repeat (2) @(negedge clk);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_q", {24'd0, q}, 32'h66);
      chk("reset_busy", {31'd0, busy}, 0);
      chk("reset_done", {31'd0, done}, 0);
    end

    do_op("lsr3", 1'b1, 2'b00, 4'd3, 8'h0C, 4, 0);
    do_load(8'h66);
    do_op("lsl2", 1'b0, 2'b00, 4'd2, 8'h98, 3, 0);
    do_load(8'h96);
    do_op("asr2", 1'b1, 2'b10, 4'd2, 8'hE5, 3, 0);
    do_load(8'h66);
    do_op("ror3", 1'b1, 2'b01, 4'd3, 8'hCC, 4, 0);
    do_op("ror9", 1'b1, 2'b01, 4'd9, 8'h66, 2, 0);
    do_op("cnt0", 1'b1, 2'b00, 4'd0, 8'h66, 1, 0);
    do_op("lsl12", 1'b0, 2'b00, 4'd12, 8'h00, 9, 0);
    do_load(8'h81);
    do_op("rol1", 1'b0, 2'b01, 4'd1, 8'h03, 2, 0);
    do_op("rsv_lsl1", 1'b0, 2'b11, 4'd1, 8'h06, 2, 0);

    // load and start together: load wins, nothing starts
    @(negedge clk);
    load = 1; start = 1; din = 8'h5A; dir = 1; mode = 2'b00; cnt = 4'd3;
    @(negedge clk);
    load = 0; start = 0;
    chk("ldst_q", {24'd0, q}, 32'h5A);
    chk("ldst_busy", {31'd0, busy}, 0);
    @(negedge clk);
    chk("ldst_busy_later", {31'd0, busy}, 0);

    // mid-shift load/start pokes must not disturb the running operation
    do_load(8'hF0);
    do_op("poke_lsr4", 1'b1, 2'b00, 4'd4, 8'h0F, 5, 1);

    // reset in the 2nd shift cycle of a cnt=5 op
    do_load(8'hF0);
    @(negedge clk);
    start = 1; dir = 1; mode = 2'b00; cnt = 4'd5;
    @(negedge clk);
    start = 0;
    chk("rst_mid_busy_before", {31'd0, busy}, 1);
    @(negedge clk);
    chk("rst_mid_q_shift1", {24'd0, q}, 32'h78);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_mid_q", {24'd0, q}, 32'h66);
    chk("rst_mid_busy", {31'd0, busy}, 0);
    chk("rst_mid_done", {31'd0, done}, 0);
    @(negedge clk);
    chk("rst_mid_done_after", {31'd0, done}, 0);
    chk("rst_mid_busy_after", {31'd0, busy}, 0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Sequencing controller for the 8-bit shift register datapath.
- Accepts a load/start command with direction, mode and shift count.
- Performs the requested shift one bit position per clock under an IDLE/SHIFT/DONE state machine.
- Reports progress through busy/done handshake outputs, so upstream logic can issue multi-bit shifts without a combinational barrel shifter.

Parameters:
- WIDTH, 8, register width; power of two, >= 2.
- CNT_W, 4, width of the shift-count input.
- INIT_VAL, 8'b01100110, register value after reset (width WIDTH).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  capture din into register (IDLE only).
- din  input  WIDTH  parallel load value.
- start  input  1  request a shift operation (level-sampled, IDLE only).
- dir  input  1  1 = right shift, 0 = left shift.
- mode  input  2  00 logical, 01 rotate, 10 arithmetic, 11 reserved (treated as logical).
- cnt  input  CNT_W  requested number of bit positions.
- q  output  WIDTH  register contents.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (synchronous, rst=1 at an edge): state=IDLE, q=INIT_VAL, busy=0, done=0, remaining=0. A reset mid-operation aborts the shift with no done pulse.
- IDLE:
  - load=1 → q<=din next edge. Load has priority: start is ignored in the same cycle.
  - start=1, load=0 → latch dir, mode and effective count into internal registers.
    - Effective count is 0 → go to DONE.
    - Otherwise → go to SHIFT.
- Effective count:
  - Logical and arithmetic modes: min(cnt, WIDTH).
  - Rotate mode: cnt mod WIDTH.
- SHIFT:
  - Each edge applies one single-position shift to q and decrements remaining.
  - On the edge where remaining==1, the last shift is applied and state goes to DONE.
  - Exactly N shift edges for effective count N.
- DONE: done=1 and busy=1 for exactly one cycle; next edge returns to IDLE.
- Latency: start accepted at edge k → q final after edge k+N → done high during cycle after edge k+N → IDLE after edge k+N+1.
- Single-step rules:
  - Logical right: MSB filled with 0.
  - Logical left: LSB filled with 0.
  - Rotate right: old LSB goes to MSB.
  - Rotate left: old MSB goes to LSB.
  - Arithmetic right: MSB replicated.
  - Arithmetic left: identical to logical left.
- While busy: start, load, din, dir, mode and cnt are ignored. Latched command values govern the whole operation.
- q holds its value in IDLE absent load; done=0 outside DONE.

Decomposition:
- Package shift_ctrl_pkg:
  - state encoding (IDLE, SHIFT, DONE).
  - mode constants (MODE_LOG, MODE_ROT, MODE_ARI).
  - direction constants (DIR_LEFT=0, DIR_RIGHT=1).
- One sub-module, shift_step: purely combinational single-position shifter (q, dir, mode → next q).
- The FSM, counter and register live in shift_sequencer.

Test Plan:
- Reset then idle 3 cycles → q=0x66, busy=0, done=0 throughout.
- start, dir=1, mode=00, cnt=3 → busy for 4 cycles, q=0x0C, done pulses once, back to IDLE. Repeat with dir=0, cnt=2 from 0x66 → q=0x98.
- load din=0x96, then start dir=1, mode=10, cnt=2 → q=0xE5. Then load 0x66 and run rotate right (mode=01) cnt=3 → q=0xCC; rotate cnt=9 → 1 shift cycle only.
- Boundary counts:
  - cnt=0 → no SHIFT cycles, done on the cycle after the start edge, q unchanged.
  - Logical left cnt=12 → exactly 8 shift cycles, q=0x00.
- Simultaneous/ignored events:
  - load and start together in IDLE → q=din, no operation started.
  - start or load pulsed mid-SHIFT → ignored, result unaffected.
- rst asserted during the 2nd shift cycle of a cnt=5 operation → next cycle q=0x66, state IDLE, busy=0, no done pulse.
